rhd_spi_master: RTL
===================

# rhd_spi_master

Host-side SPI master for the RHD2000 headstage array, driving the shared CS_n/SCLK/MOSI lines and capturing all 16 buffered single-ended MISO lines (MISO1/MISO2 of ports I..P). It accepts one 16-bit RHD command per transaction over a valid/ready handshake. It serializes the command MSB-first in SPI mode 0 and samples every MISO line with a programmable cable-delay compensation. At the end of each transaction it emits all 16 returned words in parallel.

## Interface
- CLK_DIV, 4: system clocks per SCLK half-period; must be ≥1.
- CS_HIGH_CYCLES, 8: minimum CS_n high time in clocks; must be ≥1.
- MISO_DELAY, 0: clocks between an SCLK rising edge and its MISO sample; must be in 0..CS_HIGH_CYCLES.
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- cmd_data  in  16  RHD command word.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE and not in reset.
- miso  in  16  bit 2k = MISO1 and bit 2k+1 = MISO2 of port k (k=0..7 maps to I..P).
- rsp_data  out  256  word from miso[j] at [16j+15:16j], MSB first.
- rsp_valid  out  1  one-cycle pulse when rsp_data updates.
- busy  out  1  high outside IDLE.
- CS_n, SCLK, MOSI  out  1 each  SPI lines to the headstages.

## Operation
- FSM states: IDLE → SHIFT → CS_HOLD → CS_HIGH → IDLE.
- **IDLE**: CS_n=1, SCLK=0, cmd_ready=1. A command is accepted when cmd_valid && cmd_ready, and cmd_data is latched. Later changes to cmd_data are ignored until the next accept.
- **SHIFT**: 16 bits. For each bit, SCLK is low for CLK_DIV clocks, then high for CLK_DIV clocks. MOSI updates at the start of each low phase: bit 15 first, bit 0 last.
- **CS_HOLD**: SCLK=0 and CS_n stays low for CLK_DIV clocks.
- **CS_HIGH**: CS_n=1 for CS_HIGH_CYCLES clocks.
- **Sampling**: each SCLK rising edge launches a strobe through a MISO_DELAY-stage delay line. On each strobe, all 16 miso bits are shifted into per-line 16-bit shift registers.
- **Response**: exactly 16 strobes occur per transaction. rsp_data is loaded from the shift registers, and rsp_valid pulses, in the first IDLE cycle after CS_HIGH.
- RHD returns the result of the command sent two transactions earlier. Pipelining commands against results is the host's job; this block does not track it.

## Timing
- Let t0 be the accept edge and D = CLK_DIV.
- CS_n is low over cycles t0+1 .. t0+33D.
- Bit i (i=0 is the MSB) has SCLK low over [t0+1+2iD, t0+1+(2i+1)D) and high over the following D cycles.
- CS_n is high over t0+33D+1 .. t0+33D+CS_HIGH_CYCLES.
- rsp_valid and cmd_ready are both high in cycle t0+33D+CS_HIGH_CYCLES+1; with defaults this is t0+141.
- A back-to-back accept is allowed in the rsp_valid cycle, giving a CS_n high time of CS_HIGH_CYCLES+1.
- Reset values: CS_n=1, SCLK=0, MOSI=0, rsp_valid=0, rsp_data=0, busy=0, cmd_ready=0 while rst is high.
- Reset mid-transaction: all outputs take their reset values on the next clock. The partial capture and any in-flight strobes are discarded and no rsp_valid is issued. cmd_ready returns to 1 in the first cycle after rst is deasserted.
- No combinational path from any input to any output; all outputs are registered.

## Structure
- Package rhd_pkg holds:
  - RHD_NUM_MISO=16 and RHD_WORD_W=16.
  - The FSM state enum.
  - Command constants for benches and host logic: CONVERT prefix 2'b00, WRITE 2'b10, READ 2'b11, CALIBRATE 16'h5500, CLEAR 16'h6A00.
- Sub-module rhd_miso_capture holds the strobe delay line, the 16 shift registers and the strobe counter. The top-level holds the FSM, the clock divider and the MOSI shifter.

## Test plan
- **Single command**: defaults, cmd_data=16'hC000, slave model returns 16'hA5A5 on all lines → MOSI at the 16 rising edges is 1100_0000_0000_0000; CS_n is low for 132 cycles; rsp_valid at t0+141; all 16 words are 16'hA5A5.
- **Cable delay**: per-line pattern with word j = 16'h1111*j, model delays MISO by 3 clocks, MISO_DELAY=3 → every word is exact. Repeat with MISO_DELAY=0 → words mismatch, proving the delay is applied.
- **Back-to-back**: cmd_valid held high with 16'h5500 then 16'h6A00 → second accepted in the rsp_valid cycle; CS_n high for exactly 9 cycles; both MOSI streams correct.
- **Reset mid-shift**: rst asserted at t0+60 → next cycle CS_n=1, SCLK=0, MOSI=0; no rsp_valid; a new command after reset completes correctly.
- **Minimum divider**: CLK_DIV=1 → SCLK period is 2 clocks, CS_n low for 33 cycles, 16 rising edges, correct capture.
- **Idle and ignored input**: cmd_valid low → no SCLK activity and busy=0. cmd_data toggled while busy → transmitted word is unchanged.

Source files
------------

// File: rtl/rhd_pkg.sv
// Shared types and constants for the RHD2000 SPI master and its MISO capture.
package rhd_pkg;

    localparam int RHD_NUM_MISO = 16;
    localparam int RHD_WORD_W   = 16;

    // Master FSM states, visited in this order for every transaction.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SHIFT   = 2'b01,
        ST_CS_HOLD = 2'b10,
        ST_CS_HIGH = 2'b11
    } rhd_state_e;

    // RHD command encodings for benches and host logic.
    localparam logic [1:0]  RHD_CMD_CONVERT   = 2'b00;
    localparam logic [1:0]  RHD_CMD_WRITE     = 2'b10;
    localparam logic [1:0]  RHD_CMD_READ      = 2'b11;
    localparam logic [15:0] RHD_CMD_CALIBRATE = 16'h5500;
    localparam logic [15:0] RHD_CMD_CLEAR     = 16'h6A00;

endpackage

// File: rtl/rhd_miso_capture.sv
// Cable-delay compensated capture of all 16 MISO lines into per-line shift
// registers, with a parallel response register loaded at end of transaction.
module rhd_miso_capture
    import rhd_pkg::*;
#(
    parameter int MISO_DELAY = 0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 launch_i,
    input  logic                                 load_i,
    input  logic [RHD_NUM_MISO-1:0]              miso_i,
    output logic [RHD_NUM_MISO*RHD_WORD_W-1:0]   rsp_data_o,
    output logic                                 rsp_valid_o
);

    logic                                  strobe_s;
    logic [4:0]                            scnt_q;
    logic [RHD_WORD_W-1:0]                 sh_q [RHD_NUM_MISO];
    logic [RHD_NUM_MISO*RHD_WORD_W-1:0]    rsp_data_q;
    logic                                  rsp_valid_q;

    generate
        if (MISO_DELAY == 0) begin : g_no_delay
            assign strobe_s = launch_i;
        end else begin : g_delay
            logic [MISO_DELAY-1:0] dly_q;
            // Strobe delay line: each SCLK rise walks MISO_DELAY clocks before sampling.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    dly_q <= '0;
                end else begin
                    dly_q <= (dly_q << 1) | MISO_DELAY'(launch_i);
                end
            end
            assign strobe_s = dly_q[MISO_DELAY-1];
        end
    endgenerate

    // Per-line shift registers and strobe counter; counter restarts at each load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int j = 0; j < RHD_NUM_MISO; j++) begin
                sh_q[j] <= '0;
            end
            scnt_q <= 5'd0;
        end else if (load_i) begin
            scnt_q <= 5'd0;
        end else if (strobe_s) begin
            for (int j = 0; j < RHD_NUM_MISO; j++) begin
                sh_q[j] <= {sh_q[j][RHD_WORD_W-2:0], miso_i[j]};
            end
            scnt_q <= scnt_q + 5'd1;
        end
    end

    // Parallel response register; only a complete 16-strobe capture is delivered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (load_i && (scnt_q == 5'd16)) begin
                for (int j = 0; j < RHD_NUM_MISO; j++) begin
                    rsp_data_q[j*RHD_WORD_W +: RHD_WORD_W] <= sh_q[j];
                end
                rsp_valid_q <= 1'b1;
            end
        end
    end

    assign rsp_data_o  = rsp_data_q;
    assign rsp_valid_o = rsp_valid_q;

endmodule

// File: rtl/rhd_spi_master.sv
// RHD2000 host-side SPI master (mode 0): one 16-bit command per transaction,
// MSB first, with 16 MISO words returned in parallel after CS_n deasserts.
module rhd_spi_master
    import rhd_pkg::*;
#(
    parameter int CLK_DIV        = 4,
    parameter int CS_HIGH_CYCLES = 8,
    parameter int MISO_DELAY     = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [RHD_WORD_W-1:0]              cmd_data,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [RHD_NUM_MISO-1:0]            miso,
    output logic [RHD_NUM_MISO*RHD_WORD_W-1:0] rsp_data,
    output logic                               rsp_valid,
    output logic                               busy,
    output logic                               CS_n,
    output logic                               SCLK,
    output logic                               MOSI
);

    localparam int CNT_MAX = (CLK_DIV > CS_HIGH_CYCLES) ? CLK_DIV : CS_HIGH_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CSH_LAST = CNT_W'(CS_HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    rhd_state_e              state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [3:0]              bit_q;
    logic [RHD_WORD_W-2:0]   sh_q;      // remaining bits after the one on MOSI
    logic                    cs_n_q;
    logic                    sclk_q;
    logic                    mosi_q;
    logic                    ready_q;
    logic                    busy_q;
    logic                    launch_q;  // high in the first cycle SCLK is high
    logic                    load_s;

    // Transaction FSM, SCLK divider and MOSI shifter with registered SPI outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bit_q    <= 4'd0;
            sh_q     <= '0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            launch_q <= 1'b0;
        end else begin
            launch_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cs_n_q  <= 1'b1;
                    sclk_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    if (cmd_valid && ready_q) begin
                        sh_q    <= cmd_data[RHD_WORD_W-2:0];
                        mosi_q  <= cmd_data[RHD_WORD_W-1];
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        cnt_q   <= '0;
                        bit_q   <= 4'd0;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_q <= '0;
                        if (!sclk_q) begin
                            sclk_q   <= 1'b1;
                            launch_q <= 1'b1;
                        end else if (bit_q == 4'd15) begin
                            sclk_q  <= 1'b0;
                            mosi_q  <= 1'b0;
                            state_q <= ST_CS_HOLD;
                        end else begin
                            sclk_q <= 1'b0;
                            bit_q  <= bit_q + 4'd1;
                            mosi_q <= sh_q[RHD_WORD_W-2];
                            sh_q   <= {sh_q[RHD_WORD_W-3:0], 1'b0};
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_CS_HOLD: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_q   <= '0;
                        cs_n_q  <= 1'b1;
                        state_q <= ST_CS_HIGH;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_CS_HIGH: begin
                    if (cnt_q == CSH_LAST) begin
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Response is loaded on the edge that returns the FSM to IDLE.
    assign load_s = (state_q == ST_CS_HIGH) && (cnt_q == CSH_LAST);

    rhd_miso_capture #(
        .MISO_DELAY (MISO_DELAY)
    ) u_capture (
        .clk_i       (clk),
        .rst_i       (rst),
        .launch_i    (launch_q),
        .load_i      (load_s),
        .miso_i      (miso),
        .rsp_data_o  (rsp_data),
        .rsp_valid_o (rsp_valid)
    );

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign CS_n      = cs_n_q;
    assign SCLK      = sclk_q;
    assign MOSI      = mosi_q;

endmodule
